// File: rtl/alu_seq_multiplier_if.sv
// Operand/result bundle between the control unit and the sequential multiplier.
interface alu_seq_multiplier_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Res;
    logic [WIDTH-1:0] ResHi;
    logic             busy;
    logic             done;

    // Control unit side: issues operands and start, watches the handshake
    modport master (
        output start, A, B,
        input  Res, ResHi, busy, done
    );

    // Multiplier side
    modport slave (
        input  start, A, B,
        output Res, ResHi, busy, done
    );
endinterface

// File: rtl/alu_seq_multiplier.sv
// Unsigned shift-add multiplier: WIDTH iterations per product, start/busy/done handshake.
// The product register P holds {carry, upper half, multiplier}; each RUN cycle
// conditionally adds the multiplicand into the upper part, then shifts P right.
module alu_seq_multiplier #(
    parameter int unsigned WIDTH = 32
) (
    input logic                clk,
    input logic                rst_n,
    alu_seq_multiplier_if.slave bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]    mcand_q, mcand_d;
    logic [2*WIDTH:0]    p_q, p_d;
    logic [WIDTH-1:0]    res_q, res_d;
    logic [WIDTH-1:0]    res_hi_q, res_hi_d;
    logic                busy_q, done_q;

    logic [WIDTH:0]      upper_sum;
    logic [2*WIDTH:0]    p_step;

    // One iteration of the datapath: conditional add with carry kept in P[2W], then shift
    always_comb begin
        upper_sum = p_q[2*WIDTH:WIDTH] + (p_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        p_step    = {upper_sum, p_q[WIDTH-1:0]} >> 1;
    end

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        p_d      = p_q;
        res_d    = res_q;
        res_hi_d = res_hi_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    mcand_d = bus.A;
                    p_d     = {{(WIDTH+1){1'b0}}, bus.B};
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                p_d   = p_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    res_d    = p_step[WIDTH-1:0];
                    res_hi_d = p_step[2*WIDTH-1:WIDTH];
                    state_d  = StDone;
                end
            end
            StDone: begin
                // Back-to-back start skips the IDLE cycle
                if (bus.start) begin
                    mcand_d = bus.A;
                    p_d     = {{(WIDTH+1){1'b0}}, bus.B};
                    cnt_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, datapath and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            mcand_q  <= '0;
            p_q      <= '0;
            res_q    <= '0;
            res_hi_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            p_q      <= p_d;
            res_q    <= res_d;
            res_hi_q <= res_hi_d;
            busy_q   <= (state_d == StRun);
            done_q   <= (state_d == StDone);
        end
    end

    assign bus.Res   = res_q;
    assign bus.ResHi = res_hi_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_alu_seq_multiplier.sv
// Self-checking bench for alu_seq_multiplier: directed cases plus random operands
// against a plain 64-bit multiply reference.
module tb_alu_seq_multiplier;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst_n;

    alu_seq_multiplier_if #(.WIDTH(W)) bus ();

    alu_seq_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          passed = 0;
    int          total  = 0;
    logic [63:0] exp_prod = '0;  // last completed product expected on {ResHi, Res}

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        return 64'(a) * 64'(b);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    // Present operands with start for one edge; returns at the negedge after acceptance
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
    endtask

    // Wait for done from cycle count n (cycles since acceptance), check latency and product
    task automatic finish_op(input string tag, input int n_in,
                             input logic [31:0] a, input logic [31:0] b);
        int n = n_in;
        while (bus.done !== 1'b1 && n < 60) begin
            if (n == 16) check({tag, " hold_mid"}, {bus.ResHi, bus.Res}, exp_prod);
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(32));
        check({tag, " busy_at_done"}, 64'(bus.busy), 64'(0));
        exp_prod = model(a, b);
        check({tag, " product"}, {bus.ResHi, bus.Res}, exp_prod);
    endtask

    task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b);
        start_op(a, b);
        check({tag, " busy_start"}, 64'(bus.busy), 64'(1));
        check({tag, " hold_start"}, {bus.ResHi, bus.Res}, exp_prod);
        finish_op(tag, 0, a, b);
        @(negedge clk);
        check({tag, " done_fall"}, 64'({bus.done, bus.busy}), 64'(0));
        check({tag, " hold_after"}, {bus.ResHi, bus.Res}, exp_prod);
    endtask

    initial begin
        int n;
        int done_cnt;
        int busy_cnt;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(bus.busy), 64'(0));
        check("reset done", 64'(bus.done), 64'(0));
        check("reset result", {bus.ResHi, bus.Res}, 64'(0));
        rst_n = 1'b1;

        // Directed products
        do_mul("3x5", 32'd3, 32'd5);
        check("3x5 value", {bus.ResHi, bus.Res}, 64'h0000_0000_0000_000F);
        do_mul("ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("ffxff value", {bus.ResHi, bus.Res}, 64'hFFFF_FFFE_0000_0001);
        do_mul("ax0", 32'h1234_5678, 32'd0);
        do_mul("0xb", 32'd0, 32'h9ABC_DEF0);

        // start during RUN is ignored and not queued
        start_op(32'd7, 32'd6);
        n = 0;
        repeat (5) begin @(negedge clk); n++; end
        bus.start = 1'b1;
        bus.A     = 32'd2;
        bus.B     = 32'd2;
        repeat (6) begin
            @(negedge clk);
            n++;
            bus.A = ~bus.A;
            bus.B = ~bus.B;
        end
        bus.start = 1'b0;
        finish_op("ignore", n, 32'd7, 32'd6);
        check("ignore value", {bus.ResHi, bus.Res}, 64'h2A);
        busy_cnt = 0;
        done_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done) done_cnt++;
        end
        check("ignore not_queued", 64'(busy_cnt + done_cnt), 64'(0));

        // Back-to-back: start held on the DONE cycle
        start_op(32'h1_0000, 32'h1_0000);
        n = 0;
        while (n < 31) begin @(negedge clk); n++; end
        bus.start = 1'b1;
        bus.A     = 32'd9;
        bus.B     = 32'd9;
        @(negedge clk);
        check("b2b first_done", 64'(bus.done), 64'(1));
        exp_prod = model(32'h1_0000, 32'h1_0000);
        check("b2b first_value", {bus.ResHi, bus.Res}, 64'h1_0000_0000);
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b no_gap", 64'({bus.busy, bus.done}), 64'b10);
        finish_op("b2b second", 0, 32'd9, 32'd9);
        check("b2b second_value", {bus.ResHi, bus.Res}, 64'h51);

        // Asynchronous reset mid-operation
        start_op(32'd100, 32'd100);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst busy", 64'(bus.busy), 64'(0));
        check("async_rst done", 64'(bus.done), 64'(0));
        check("async_rst result", {bus.ResHi, bus.Res}, 64'(0));
        exp_prod = '0;
        @(negedge clk);
        rst_n    = 1'b1;
        busy_cnt = 0;
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done) done_cnt++;
        end
        check("async_rst no_done", 64'(done_cnt), 64'(0));
        check("async_rst idle", 64'(busy_cnt), 64'(0));
        do_mul("after_rst", 32'd100, 32'd100);
        check("after_rst value", {bus.ResHi, bus.Res}, 64'h2710);

        // Random operands against the reference multiply
        for (int i = 0; i < 6; i++) begin
            do_mul("rand", $urandom, $urandom);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
